sigmoid_seg_search: RTL and testbench



---
 rtl/sigmoid_seg_search.sv | 184 ++++++++++++++++++
 tb/tb_sigmoid_seg_search.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_seg_search.sv
// Binary search of the sigmoid/tanh breakpoint table for the segment holding |x|.
// Optional macro SEG_SEARCH_SAT_FASTPATH_EN: saturated inputs bypass the search.
module sigmoid_seg_search #(
  parameter int unsigned    xDW   = 24,
  parameter int unsigned    ML    = 196,
  parameter int unsigned    MW    = 8,
  parameter logic [xDW-1:0] SAT_X = 24'h040000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [xDW-1:0] x_in,
  output logic [MW-1:0]  tbl_j,
  input  logic [xDW-1:0] tbl_half_j,
  input  logic [xDW-1:0] tbl_half_j_1,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [MW-1:0]  seg_j,
  output logic [xDW-1:0] seg_lo,
  output logic [xDW-1:0] seg_hi,
  output logic [xDW-1:0] x_abs,
  output logic           x_neg,
  output logic           x_sat
);

`ifdef SEG_SEARCH_SAT_FASTPATH_EN
  localparam bit FASTPATH = 1'b1;
`else
  localparam bit FASTPATH = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_FETCH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [MW-1:0]  LO_INIT  = MW'(1);
  localparam logic [MW-1:0]  HI_INIT  = MW'(ML + 1);
  localparam logic [MW-1:0]  LO_SAT   = MW'(ML);
  localparam logic [MW-1:0]  MID_INIT = MW'((ML + 2) / 2);
  localparam logic [xDW-1:0] MOST_NEG = {1'b1, {(xDW-1){1'b0}}};
  localparam logic [xDW-1:0] MAX_POS  = {1'b0, {(xDW-1){1'b1}}};

  state_t         r_state, w_state_nxt;
  logic [xDW-1:0] r_a;
  logic [MW-1:0]  r_lo, r_hi, r_tbl_j;
  logic           r_in_ready, r_out_valid, r_x_neg, r_x_sat;
  logic [MW-1:0]  r_seg_j;
  logic [xDW-1:0] r_seg_lo, r_seg_hi, r_x_abs;

  logic [xDW-1:0] w_abs;
  logic           w_sat, w_accept, w_le, w_converged;
  logic [MW-1:0]  w_lo_nxt, w_hi_nxt, w_mid_nxt;

  // Magnitude with the most-negative code clamped to the largest positive value.
  always_comb begin
    w_abs = x_in;
    if (x_in == MOST_NEG) begin
      w_abs = MAX_POS;
    end else if (x_in[xDW-1]) begin
      w_abs = ~x_in + xDW'(1);
    end else begin
      w_abs = x_in;
    end
  end

  assign w_sat    = (w_abs >= SAT_X);
  assign w_accept = (r_state == S_IDLE) && in_valid;

  // r_tbl_j holds mid while searching, so the LUT answer for mid is already present.
  assign w_le        = (tbl_half_j <= r_a);
  assign w_lo_nxt    = w_le ? r_tbl_j : r_lo;
  assign w_hi_nxt    = w_le ? r_hi : r_tbl_j;
  assign w_converged = ((w_hi_nxt - w_lo_nxt) == MW'(1));
  assign w_mid_nxt   = MW'(({1'b0, w_lo_nxt} + {1'b0, w_hi_nxt}) >> 1);

  // Next-state decision.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (FASTPATH && w_sat) ? S_FETCH : S_SEARCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SEARCH: begin
        if (w_converged) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_SEARCH;
        end
      end
      S_FETCH: w_state_nxt = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Search datapath, result capture and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_tbl_j     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_x_neg     <= 1'b0;
      r_x_sat     <= 1'b0;
      r_seg_j     <= '0;
      r_seg_lo    <= '0;
      r_seg_hi    <= '0;
      r_x_abs     <= '0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= w_abs;
            r_x_neg <= x_in[xDW-1];
            r_x_sat <= w_sat;
            r_hi    <= HI_INIT;
            if (FASTPATH && w_sat) begin
              r_lo    <= LO_SAT;
              r_tbl_j <= LO_SAT;
            end else begin
              r_lo    <= LO_INIT;
              r_tbl_j <= MID_INIT;
            end
          end
        end
        S_SEARCH: begin
          r_lo    <= w_lo_nxt;
          r_hi    <= w_hi_nxt;
          r_tbl_j <= w_converged ? w_lo_nxt : w_mid_nxt;
        end
        S_FETCH: begin
          r_seg_j  <= r_lo;
          r_seg_lo <= tbl_half_j;
          r_seg_hi <= tbl_half_j_1;
          r_x_abs  <= r_a;
        end
        S_DONE: begin
          r_tbl_j <= r_tbl_j;
        end
        default: begin
          r_tbl_j <= r_tbl_j;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign tbl_j     = r_tbl_j;
  assign seg_j     = r_seg_j;
  assign seg_lo    = r_seg_lo;
  assign seg_hi    = r_seg_hi;
  assign x_abs     = r_x_abs;
  assign x_neg     = r_x_neg;
  assign x_sat     = r_x_sat;

endmodule

// File: tb/tb_sigmoid_seg_search.sv
// Scoreboard bench for sigmoid_seg_search with a breakpoint LUT model and a linear-scan reference.
module tb_sigmoid_seg_search;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] x_in;
  logic [7:0]  tbl_j;
  logic [23:0] tbl_half_j;
  logic [23:0] tbl_half_j_1;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  seg_j;
  logic [23:0] seg_lo;
  logic [23:0] seg_hi;
  logic [23:0] x_abs;
  logic        x_neg;
  logic        x_sat;

`ifdef SEG_SEARCH_SAT_FASTPATH_EN
  localparam int SAT_LAT = 1;
`else
  localparam int SAT_LAT = 9;
`endif

  typedef struct {
    logic [7:0]  j;
    logic [23:0] lo;
    logic [23:0] hi;
    logic [23:0] a;
    logic        neg;
    logic        sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  int   rdy_mode = 0;
  logic prev_ov = 1'b0;

  sigmoid_seg_search dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .tbl_j(tbl_j), .tbl_half_j(tbl_half_j), .tbl_half_j_1(tbl_half_j_1),
    .out_valid(out_valid), .out_ready(out_ready), .seg_j(seg_j), .seg_lo(seg_lo),
    .seg_hi(seg_hi), .x_abs(x_abs), .x_neg(x_neg), .x_sat(x_sat)
  );

  // Monotonic breakpoint table, entries 0..197; entry 197 equals the saturation point.
  function automatic logic [23:0] bp(input int k);
    if (k <= 1)        return 24'h000000;
    else if (k == 2)   return 24'h000400;
    else if (k <= 100) return 24'(13312 + (k - 24) * 256);
    else if (k <= 159) return 24'(65536 - (159 - k) * 512);
    else if (k <= 169) return 24'(65536 + (k - 159) * 1024);
    else if (k <= 196) return 24'(131072 - (196 - k) * 2048);
    else if (k == 197) return 24'h040000;
    else               return 24'hFFFFFF;
  endfunction

  function automatic logic [23:0] magnitude(input logic [23:0] x);
    if (x == 24'h800000) return 24'h7FFFFF;
    else if (x[23])      return 24'h000000 - x;
    else                 return x;
  endfunction

  // Largest segment 1..196 whose lower bound does not exceed a.
  function automatic int ref_j(input logic [23:0] a);
    int j = 1;
    for (int k = 1; k <= 196; k++) begin
      if (bp(k) <= a) j = k;
    end
    return j;
  endfunction

  function automatic exp_t model(input logic [23:0] x);
    exp_t e;
    int   j;
    e.a   = magnitude(x);
    e.neg = x[23];
    e.sat = (e.a >= 24'h040000);
    j     = ref_j(e.a);
    e.j   = 8'(j);
    e.lo  = bp(j);
    e.hi  = bp(j + 1);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always_comb begin
    tbl_half_j   = bp(int'(tbl_j));
    tbl_half_j_1 = bp(int'(tbl_j) + 1);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter and accept-edge timestamp for latency measurement.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready && !rst) acc_cyc <= cyc;
  end

  // Downstream ready: random, forced low or forced high.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: latency on each new result, field comparison on each handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && !prev_ov) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else if (exp_q[0].sat) begin
        chk("latency_sat", 32'(cyc - acc_cyc - 1), 32'(SAT_LAT));
      end else begin
        chk("latency_range", {31'd0, ((cyc - acc_cyc - 1) >= 2) && ((cyc - acc_cyc - 1) <= 9)}, 32'd1);
      end
    end
    prev_ov = out_valid;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("result_without_input", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("seg_j",  32'(seg_j),  32'(e.j));
        chk("seg_lo", 32'(seg_lo), 32'(e.lo));
        chk("seg_hi", 32'(seg_hi), 32'(e.hi));
        chk("x_abs",  32'(x_abs),  32'(e.a));
        chk("x_neg",  32'(x_neg),  32'(e.neg));
        chk("x_sat",  32'(x_sat),  32'(e.sat));
      end
    end
  end

  task automatic send(input logic [23:0] x);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      in_valid = 1'b1;
      x_in     = x;
      exp_q.push_back(model(x));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_seg_j"},     32'(seg_j),     32'd0);
    chk({tag, "_seg_lo"},    32'(seg_lo),    32'd0);
    chk({tag, "_seg_hi"},    32'(seg_hi),    32'd0);
    chk({tag, "_x_abs"},     32'(x_abs),     32'd0);
    chk({tag, "_x_neg"},     32'(x_neg),     32'd0);
    chk({tag, "_x_sat"},     32'(x_sat),     32'd0);
    chk({tag, "_tbl_j"},     32'(tbl_j),     32'd0);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [23:0] x;
    logic [23:0] mag;
    int          t;
    rst      = 1'b1;
    in_valid = 1'b0;
    x_in     = 24'h000000;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    send(24'h000000);
    send(24'h003480);
    send(24'hFF0000);
    send(24'h7FFFFF);
    send(24'h800000);
    send(24'h040000);
    send(24'h03FFFF);
    drain();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       mag = 24'($urandom_range(0, 32'h03FFFF));
        1:       mag = bp($urandom_range(1, 197));
        2:       mag = bp($urandom_range(2, 197)) - 24'h000001;
        default: mag = 24'($urandom);
      endcase
      x = ($urandom_range(0, 1) == 1) ? (24'h000000 - mag) : mag;
      send(x);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    rdy_mode = 1;
    send(24'h003480);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      x_in     = 24'h000100;
      chk("bp_hold_valid",    32'(out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready),  32'd0);
      chk("bp_hold_seg_j",    32'(seg_j),     32'd24);
      chk("bp_hold_seg_lo",   32'(seg_lo),    32'h003400);
      chk("bp_hold_seg_hi",   32'(seg_hi),    32'h003500);
      chk("bp_hold_x_abs",    32'(x_abs),     32'h003480);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rdy_mode = 2;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready",  32'(in_ready),  32'd1);
    rdy_mode = 0;
    drain();

    send(24'h001234);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check_reset_values("midrst");
    rst = 1'b0;
    send(24'h000500);
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
